// File: rtl/corr_lag_scanner.sv
// Lag scanner: steps lag_sel over all lags, integrates pwr_in per lag and reports the peak.
// Optional macro CORR_SCAN_THRESHOLD_EN adds a threshold input and a one-cycle trigger at DONE entry.
module corr_lag_scanner #(
    parameter int NLAGS   = 16,
    parameter int LAGBITS = 4,
    parameter int PWRBITS = 11,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           int_len,
    output logic [LAGBITS-1:0]   lag_sel,
    input  logic [PWRBITS-1:0]   pwr_in,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic [PWRBITS+7:0]   peak_pwr,
    output logic [LAGBITS-1:0]   peak_lag,
`ifdef CORR_SCAN_THRESHOLD_EN
    input  logic [PWRBITS+7:0]   threshold,
`endif
    output logic                 trigger
);

    localparam int ACCW = PWRBITS + 8;
    localparam logic [7:0] SETTLE_INIT = 8'(LATENCY - 1);
    localparam logic [LAGBITS-1:0] LAST_LAG = LAGBITS'(NLAGS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_INTEG  = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           len_q, len_d;
    logic [LAGBITS-1:0]   lag_q, lag_d;
    logic [ACCW-1:0]      acc_q, acc_d;
    logic [ACCW-1:0]      peak_pwr_q, peak_pwr_d;
    logic [LAGBITS-1:0]   peak_lag_q, peak_lag_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 upd_s;
    logic [ACCW-1:0]      new_peak_s;
`ifdef CORR_SCAN_THRESHOLD_EN
    logic                 trig_q, trig_d;
`endif

    // Next-state and datapath update for the scan sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        lag_d      = lag_q;
        acc_d      = acc_q;
        peak_pwr_d = peak_pwr_q;
        peak_lag_d = peak_lag_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
`ifdef CORR_SCAN_THRESHOLD_EN
        trig_d     = 1'b0;
`endif
        // Strict compare keeps the lower lag on ties
        upd_s      = (acc_q > peak_pwr_q);
        new_peak_s = upd_s ? acc_q : peak_pwr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = int_len;
                    lag_d      = '0;
                    acc_d      = '0;
                    peak_pwr_d = '0;
                    peak_lag_d = '0;
                    busy_d     = 1'b1;
                    cnt_d      = SETTLE_INIT;
                    state_d    = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = (len_q == 8'd0) ? 8'd0 : (len_q - 8'd1);
                    state_d = S_INTEG;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_INTEG: begin
                acc_d = acc_q + ACCW'(pwr_in);
                if (cnt_q == 8'd0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_NEXT: begin
                acc_d      = '0;
                peak_pwr_d = new_peak_s;
                if (upd_s) begin
                    peak_lag_d = lag_q;
                end else begin
                    peak_lag_d = peak_lag_q;
                end
                if (lag_q == LAST_LAG) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DONE;
`ifdef CORR_SCAN_THRESHOLD_EN
                    trig_d  = (new_peak_s > threshold);
`endif
                end else begin
                    lag_d   = lag_q + LAGBITS'(1);
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            len_q      <= 8'd0;
            lag_q      <= '0;
            acc_q      <= '0;
            peak_pwr_q <= '0;
            peak_lag_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef CORR_SCAN_THRESHOLD_EN
            trig_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            lag_q      <= lag_d;
            acc_q      <= acc_d;
            peak_pwr_q <= peak_pwr_d;
            peak_lag_q <= peak_lag_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
`ifdef CORR_SCAN_THRESHOLD_EN
            trig_q     <= trig_d;
`endif
        end
    end

    assign lag_sel      = lag_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign peak_pwr     = peak_pwr_q;
    assign peak_lag     = peak_lag_q;
`ifdef CORR_SCAN_THRESHOLD_EN
    assign trigger      = trig_q;
`else
    assign trigger      = 1'b0;
`endif

endmodule

// File: tb/tb_corr_lag_scanner.sv
// Scoreboard bench for corr_lag_scanner: directed scans push expected peak/lag/finish-cycle;
// a negedge monitor pops and compares on each result_valid rise.
module tb_corr_lag_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  int_len = 8'd0;
    logic [3:0]  lag_sel;
    logic [10:0] pwr_in;
    logic        busy;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic [18:0] peak_pwr;
    logic [3:0]  peak_lag;
    logic        trigger;
    logic [18:0] thr = 19'd179;

    typedef struct {
        int pwr;
        int lag;
        int done_cyc;
        bit trig;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   mode = 0;
    int   trig_seen = 0;
    int   trig_exp = 0;
    logic prev_valid = 1'b0;
    logic [3:0] pipe [0:2];

    corr_lag_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .int_len      (int_len),
        .lag_sel      (lag_sel),
        .pwr_in       (pwr_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .peak_pwr     (peak_pwr),
        .peak_lag     (peak_lag),
`ifdef CORR_SCAN_THRESHOLD_EN
        .threshold    (thr),
`endif
        .trigger      (trigger)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Three-cycle delay/add-and-square stand-in: power follows lag_sel after LATENCY cycles
    always @(posedge clk) begin
        pipe[0] <= lag_sel;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    always_comb begin
        pwr_in = 11'd0;
        case (mode)
            0: pwr_in = 11'(pipe[2] * 3);
            1: pwr_in = 11'd5;
            2: pwr_in = (pipe[2] == 4'd3 || pipe[2] == 4'd9) ? 11'd50 : 11'd7;
            3: pwr_in = 11'd2047;
            default: pwr_in = 11'd0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per rising result_valid
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (trigger) trig_seen = trig_seen + 1;
            if (result_valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("peak_pwr", int'(peak_pwr), e.pwr);
                    check("peak_lag", int'(peak_lag), e.lag);
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_at_done", int'(busy), 0);
                    check("trigger_at_done", int'(trigger), int'(e.trig));
                end
            end
            prev_valid = result_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_start(input int len, input int m, input int epwr,
                                  input int elag, input int dur, input bit expect_result);
        exp_t e;
        tick();
        mode = m;
        int_len = 8'(len);
        start = 1'b1;
        if (expect_result) begin
            e.pwr = epwr;
            e.lag = elag;
            e.done_cyc = cyc + dur;
`ifdef CORR_SCAN_THRESHOLD_EN
            e.trig = (epwr > int'(thr));
`else
            e.trig = 1'b0;
`endif
            if (e.trig) trig_exp = trig_exp + 1;
            sbq.push_back(e);
        end
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!result_valid && n < budget) begin
            tick();
            n = n + 1;
        end
        check("valid_within_budget", int'(result_valid), 1);
    endtask

    task automatic ack_now();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("valid_after_ack", int'(result_valid), 0);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_lag_sel", int'(lag_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_peak_pwr", int'(peak_pwr), 0);
        check("rst_peak_lag", int'(peak_lag), 0);
        check("rst_trigger", int'(trigger), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Ramp power, int_len=4: peak at last lag, hold 10 cycles, then ack+start together
        push_and_start(4, 0, 180, 15, 129, 1'b1);
        wait_valid(200);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", int'(result_valid), 1);
            check("hold_peak_pwr", int'(peak_pwr), 180);
            check("hold_peak_lag", int'(peak_lag), 15);
        end
        result_ack = 1'b1;
        start = 1'b1;
        tick();
        result_ack = 1'b0;
        start = 1'b0;
        check("ackstart_valid", int'(result_valid), 0);
        check("ackstart_busy", int'(busy), 0);
        repeat (3) tick();
        check("idle_busy", int'(busy), 0);
        check("idle_keep_pwr", int'(peak_pwr), 180);
        check("idle_keep_lag", int'(peak_lag), 15);

        // int_len=0 behaves as one cycle; equal powers keep lag 0
        thr = 19'd180;
        push_and_start(0, 1, 5, 0, 81, 1'b1);
        wait_valid(200);
        ack_now();

        // Spurious start and ack while busy change nothing
        push_and_start(4, 0, 180, 15, 129, 1'b1);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("busy_after_noise", int'(busy), 1);
        wait_valid(200);
        ack_now();

        // Nonzero tie between lags 3 and 9
        push_and_start(2, 2, 100, 3, 97, 1'b1);
        wait_valid(200);
        ack_now();

        // Asynchronous reset during lag 7 integration aborts the scan
        push_and_start(4, 0, 0, 0, 0, 1'b0);
        n = 0;
        while (lag_sel != 4'd7 && n < 200) begin
            tick();
            n = n + 1;
        end
        check("reached_lag7", int'(lag_sel), 7);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_lag_sel", int'(lag_sel), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(result_valid), 0);
        check("abort_peak_pwr", int'(peak_pwr), 0);
        check("abort_peak_lag", int'(peak_lag), 0);
        check("abort_trigger", int'(trigger), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        push_and_start(4, 0, 180, 15, 129, 1'b1);
        wait_valid(200);
        ack_now();

        // Longest integration at full-scale power: accumulator headroom
        push_and_start(255, 3, 521985, 0, 4145, 1'b1);
        wait_valid(5000);
        ack_now();

        repeat (3) tick();
        check("scoreboard_drained", sbq.size(), 0);
        check("trigger_pulses", trig_seen, trig_exp);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/corr_lag_scanner.md
CORR_LAG_SCANNER -- requirements
Module: corr_lag_scanner

Interface
REQ-001 SHALL have parameter NLAGS, default 16: number of lag settings scanned, 2..256.
REQ-002 SHALL have parameter LAGBITS, default 4: lag index width, at least clog2(NLAGS).
REQ-003 SHALL have parameter PWRBITS, default 11: per-cycle summed power width.
REQ-004 SHALL have parameter LATENCY, default 3: datapath cycles from a lag change to valid power, 1..15.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle scan request.
REQ-008 SHALL have port int_len, input, 8: integration cycles per lag; sampled on accepted start.
REQ-009 SHALL have port lag_sel, output, LAGBITS: lag index driven to the delay/add-and-square datapath.
REQ-010 SHALL have port pwr_in, input, PWRBITS: summed power for the current cycle.
REQ-011 SHALL have port busy, output, 1: high from accepted start until result_valid rises.
REQ-012 SHALL have port result_valid, output, 1: peak result available.
REQ-013 SHALL have port result_ack, input, 1: consumer acknowledge.
REQ-014 SHALL have port peak_pwr, output, PWRBITS+8: maximum integrated power.
REQ-015 SHALL have port peak_lag, output, LAGBITS: lag index of peak_pwr.
REQ-016 SHALL have port trigger, output, 1: threshold-exceeded pulse (see Configuration).

Function
REQ-017 SHALL implement states IDLE, SETTLE, INTEG, NEXT, DONE.
REQ-018 IDLE: start=1 SHALL capture int_len, set lag_sel=0, clear peak, assert busy, go to SETTLE next cycle.
REQ-019 start while not in IDLE SHALL be ignored.
REQ-020 SETTLE SHALL last exactly LATENCY cycles, discarding pwr_in, then enter INTEG.
REQ-021 INTEG SHALL accumulate pwr_in for exactly max(int_len,1) cycles into a PWRBITS+8-bit accumulator; no overflow is possible.
REQ-022 NEXT (1 cycle) SHALL compare the accumulator to peak_pwr; strictly greater updates peak_pwr/peak_lag (ties keep the lower lag); accumulator cleared.
REQ-023 NEXT SHALL increment lag_sel and go to SETTLE if lag_sel<NLAGS-1, else go to DONE; lag_sel SHALL NOT wrap mid-scan.
REQ-024 DONE SHALL assert result_valid, deassert busy, and hold peak_pwr/peak_lag stable until result_ack.
REQ-025 result_ack=1 in DONE SHALL return to IDLE next cycle with result_valid=0; result_ack in other states SHALL be ignored.
REQ-026 start and result_ack in the same DONE cycle SHALL ack only; start SHALL NOT be accepted that cycle.
REQ-027 Scan duration from start to result_valid SHALL be exactly 1+NLAGS*(LATENCY+max(int_len,1)+1) cycles.
REQ-028 peak_pwr/peak_lag SHALL retain the last result in IDLE until the next accepted start.

Reset
REQ-029 rst=1 SHALL, asynchronously, force IDLE, lag_sel=0, busy=0, result_valid=0, peak_pwr=0, peak_lag=0, accumulator=0, trigger=0.
REQ-030 rst asserted mid-scan SHALL abort the scan with no result; the first start after release SHALL behave as from power-up.

Configuration
REQ-031 Macro CORR_SCAN_THRESHOLD_EN defined SHALL add input threshold (PWRBITS+8 bits) and pulse trigger for one cycle on entry to DONE when peak_pwr > threshold.
REQ-032 Without CORR_SCAN_THRESHOLD_EN, no threshold port SHALL exist and trigger SHALL be constant 0.

Verification
REQ-033 Defaults, int_len=4, pwr_in=lag_sel*3 -> result_valid after 129 cycles, peak_lag=15, peak_pwr=180.
REQ-034 int_len=0, pwr_in=5 constant -> each lag integrates 1 cycle, peak_lag=0 (tie rule), peak_pwr=5, duration 81 cycles.
REQ-035 start pulsed again mid-scan and result_ack asserted while busy -> no restart, no effect, result timing unchanged.
REQ-036 rst at lag 7 during INTEG -> immediate IDLE, outputs zeroed; next start produces full correct scan.
REQ-037 result_valid held 10 cycles without ack -> outputs stable; ack+start same cycle -> IDLE, start ignored.
REQ-038 With CORR_SCAN_THRESHOLD_EN, threshold=179 vs 180 with REQ-033 stimulus -> single trigger pulse at DONE entry vs none.
